// File: rtl/wordle_pkg.sv
// Shared types and helpers for the Wordle engine: letter width, state
// encoding and pack/unpack functions for packed letter vectors.
package wordle_pkg;

    localparam int LETTER_W    = 5;
    localparam int LETTER_LAST = 25;
    localparam int MAX_LETTERS = 8;
    localparam int MAX_W       = LETTER_W * MAX_LETTERS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_SCORE  = 3'd2,
        S_RESULT = 3'd3,
        S_WIN    = 3'd4,
        S_LOSE   = 3'd5
    } state_t;

    // Read letter i from a packed word (position 0 in the LSBs).
    function automatic logic [LETTER_W-1:0] letter_at(
        input logic [MAX_W-1:0] w,
        input int               i
    );
        return w[i*LETTER_W +: LETTER_W];
    endfunction

    // Return a copy of w with letter i replaced by l.
    function automatic logic [MAX_W-1:0] letter_put(
        input logic [MAX_W-1:0]    w,
        input int                  i,
        input logic [LETTER_W-1:0] l
    );
        logic [MAX_W-1:0] r;
        r = w;
        r[i*LETTER_W +: LETTER_W] = l;
        return r;
    endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Guess scorer: one cycle of positional (exact) compare, then one guess
// position per cycle for the present search with duplicate-letter handling.
// Ports: clk, reset (async, active-low), start (pulse), clear (zero masks),
//        guess/secret (packed words), exact_mask, present_mask, done (pulse).
module wordle_scorer
    import wordle_pkg::*;
#(
    parameter int WORD_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear,
    input  logic [LETTER_W*WORD_LEN-1:0] guess,
    input  logic [LETTER_W*WORD_LEN-1:0] secret,
    output logic [WORD_LEN-1:0]          exact_mask,
    output logic [WORD_LEN-1:0]          present_mask,
    output logic                         done
);

    localparam int IW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    logic [WORD_LEN-1:0] used;
    logic [WORD_LEN-1:0] eq;
    logic [WORD_LEN-1:0] sel;
    logic [IW-1:0]       idx;
    logic                busy;
    logic                hit;
    logic [LETTER_W-1:0] g_cur;

    always_comb begin
        eq = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            eq[i] = letter_at(MAX_W'(guess), i) == letter_at(MAX_W'(secret), i);
        end
    end

    // Lowest unused secret position holding the current guess letter.
    always_comb begin
        g_cur = letter_at(MAX_W'(guess), int'(idx));
        hit   = 1'b0;
        sel   = '0;
        for (int j = 0; j < WORD_LEN; j++) begin
            if (!hit && !used[j] &&
                letter_at(MAX_W'(secret), j) == g_cur) begin
                hit    = 1'b1;
                sel[j] = 1'b1;
            end
        end
    end

    assign done = busy && (idx == IW'(WORD_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exact_mask   <= '0;
            present_mask <= '0;
            used         <= '0;
            idx          <= '0;
            busy         <= 1'b0;
        end else if (clear) begin
            exact_mask   <= '0;
            present_mask <= '0;
            busy         <= 1'b0;
        end else if (start) begin
            exact_mask   <= eq;
            present_mask <= '0;
            used         <= eq;
            idx          <= '0;
            busy         <= 1'b1;
        end else if (busy) begin
            // Exact positions already own their secret letter.
            if (!exact_mask[idx] && hit) begin
                present_mask[idx] <= 1'b1;
                used              <= used | sel;
            end
            if (done) begin
                busy <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordle_core.sv
// Wordle game engine: button press detection, guess entry/editing, secret
// storage, guess counting and win/lose verdict around the scorer.
// Ports: clk, reset (async, active-low), enter/back (active-low buttons),
//        letter_in, secret_load/secret_in, state_o, cursor, guess_word,
//        exact_mask, present_mask, guess_count, score_done, win, lose.
module wordle_core
    import wordle_pkg::*;
#(
    parameter int                           WORD_LEN       = 4,
    parameter int                           MAX_GUESSES    = 6,
    parameter logic [LETTER_W*WORD_LEN-1:0] SECRET_DEFAULT = 20'h4CD01
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enter,
    input  logic                             back,
    input  logic [LETTER_W-1:0]              letter_in,
    input  logic                             secret_load,
    input  logic [LETTER_W*WORD_LEN-1:0]     secret_in,
    output logic [2:0]                       state_o,
    output logic [$clog2(WORD_LEN+1)-1:0]    cursor,
    output logic [LETTER_W*WORD_LEN-1:0]     guess_word,
    output logic [WORD_LEN-1:0]              exact_mask,
    output logic [WORD_LEN-1:0]              present_mask,
    output logic [$clog2(MAX_GUESSES+1)-1:0] guess_count,
    output logic                             score_done,
    output logic                             win,
    output logic                             lose
);

    localparam int CW  = $clog2(WORD_LEN + 1);
    localparam int GCW = $clog2(MAX_GUESSES + 1);
    localparam int GW  = LETTER_W * WORD_LEN;

    state_t         state, state_nx;
    logic           enter_q, back_q;
    logic           ent_p, bck_p;
    logic           valid, last_letter, clear, start_q;
    logic [GW-1:0]  secret_q, guess_q;
    logic [CW-1:0]  cur_q;
    logic [GCW-1:0] cnt_q, cnt_inc;

    assign ent_p       = enter_q & ~enter;
    assign bck_p       = back_q & ~back;
    assign valid       = letter_in <= LETTER_W'(LETTER_LAST);
    assign last_letter = valid && (cur_q == CW'(WORD_LEN - 1));
    assign cnt_inc     = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ent_p) begin
                    state_nx = S_ENTRY;
                    clear    = 1'b1;
                end
            end
            S_ENTRY: begin
                if (ent_p && last_letter) begin
                    state_nx = S_SCORE;
                end
            end
            S_SCORE: begin
                if (score_done) begin
                    if (&exact_mask) begin
                        state_nx = S_WIN;
                    end else if (cnt_inc == GCW'(MAX_GUESSES)) begin
                        state_nx = S_LOSE;
                    end else begin
                        state_nx = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (ent_p) begin
                    state_nx = S_ENTRY;
                    clear    = 1'b1;
                end
            end
            S_WIN, S_LOSE: begin
                if (ent_p) begin
                    state_nx = S_IDLE;
                    clear    = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_q  <= 1'b1;
            back_q   <= 1'b1;
            secret_q <= SECRET_DEFAULT;
            guess_q  <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            enter_q <= enter;
            back_q  <= back;
            start_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (secret_load) begin
                        secret_q <= secret_in;
                    end
                    if (ent_p) begin
                        cur_q   <= '0;
                        guess_q <= '0;
                    end
                end
                S_ENTRY: begin
                    // A simultaneous back press is dropped.
                    if (ent_p) begin
                        if (valid) begin
                            guess_q <= GW'(letter_put(MAX_W'(guess_q),
                                                      int'(cur_q), letter_in));
                            cur_q   <= cur_q + 1'b1;
                            start_q <= last_letter;
                        end
                    end else if (bck_p && cur_q != '0) begin
                        guess_q <= GW'(letter_put(MAX_W'(guess_q),
                                                  int'(cur_q) - 1, '0));
                        cur_q   <= cur_q - 1'b1;
                    end
                end
                S_SCORE: begin
                    if (score_done) begin
                        cnt_q <= cnt_inc;
                    end
                end
                S_RESULT: begin
                    if (ent_p) begin
                        cur_q   <= '0;
                        guess_q <= '0;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (ent_p) begin
                        cnt_q   <= '0;
                        guess_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    wordle_scorer #(
        .WORD_LEN(WORD_LEN)
    ) u_scorer (
        .clk         (clk),
        .reset       (reset),
        .start       (start_q),
        .clear       (clear),
        .guess       (guess_q),
        .secret      (secret_q),
        .exact_mask  (exact_mask),
        .present_mask(present_mask),
        .done        (score_done)
    );

    assign state_o     = state;
    assign cursor      = cur_q;
    assign guess_word  = guess_q;
    assign guess_count = cnt_q;
    assign win         = (state == S_WIN);
    assign lose        = (state == S_LOSE);

endmodule

// File: tb/tb_wordle_core.sv
// Randomized self-checking bench for wordle_core with a letter-count
// Wordle reference model; WORD_LEN=4, MAX_GUESSES=6.
module tb_wordle_core;

    logic        clk = 1'b0;
    logic        reset, enter, back, secret_load;
    logic [4:0]  letter_in;
    logic [19:0] secret_in;
    logic [2:0]  state_o, cursor, guess_count;
    logic [19:0] guess_word;
    logic [3:0]  exact_mask, present_mask;
    logic        score_done, win, lose;

    int n_chk = 0;
    int n_pass = 0;

    // Default secret 20'h4CD01 decodes to letters 1,8,19,9.
    localparam logic [19:0] DEF_SECRET = 20'h4CD01;

    always #5 clk = ~clk;

    wordle_core #(
        .WORD_LEN(4),
        .MAX_GUESSES(6),
        .SECRET_DEFAULT(20'h4CD01)
    ) dut (
        .clk(clk), .reset(reset), .enter(enter), .back(back),
        .letter_in(letter_in), .secret_load(secret_load),
        .secret_in(secret_in), .state_o(state_o), .cursor(cursor),
        .guess_word(guess_word), .exact_mask(exact_mask),
        .present_mask(present_mask), .guess_count(guess_count),
        .score_done(score_done), .win(win), .lose(lose)
    );

    function automatic logic [19:0] word4(int a, int b, int c, int d);
        return {d[4:0], c[4:0], b[4:0], a[4:0]};
    endfunction

    function automatic logic [19:0] rand_word();
        return word4($urandom_range(25, 0), $urandom_range(25, 0),
                     $urandom_range(25, 0), $urandom_range(25, 0));
    endfunction

    // Standard Wordle: exact letters first, then greens/yellows share the
    // remaining letter counts left to right.
    task automatic model_score(input logic [19:0] sec, input logic [19:0] g,
                               output logic [3:0] ex, output logic [3:0] pr);
        int cnt[32];
        int s, l;
        for (int k = 0; k < 32; k++) cnt[k] = 0;
        ex = '0;
        pr = '0;
        for (int i = 0; i < 4; i++) begin
            s = int'(sec[5*i +: 5]);
            l = int'(g[5*i +: 5]);
            if (s == l) ex[i] = 1'b1;
            else cnt[s]++;
        end
        for (int i = 0; i < 4; i++) begin
            l = int'(g[5*i +: 5]);
            if (!ex[i] && cnt[l] > 0) begin
                pr[i] = 1'b1;
                cnt[l]--;
            end
        end
    endtask

    task automatic press(input logic [4:0] l, input bit e, input bit b);
        @(negedge clk);
        letter_in = l;
        enter = e ? 1'b0 : 1'b1;
        back = b ? 1'b0 : 1'b1;
        @(negedge clk);
        enter = 1'b1;
        back = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_secret(input logic [19:0] sec);
        @(negedge clk);
        secret_load = 1'b1;
        secret_in = sec;
        @(negedge clk);
        secret_load = 1'b0;
    endtask

    task automatic enter_word(input logic [19:0] g);
        for (int i = 0; i < 4; i++) press(g[5*i +: 5], 1'b1, 1'b0);
    endtask

    // Returns the negedge index (1 = right after last press) of score_done.
    task automatic wait_score(output int cyc);
        int k;
        k = 1;
        while (score_done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        cyc = k;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d want 0", state_o); else n_pass++;
        n_chk++; if (cursor !== 3'd0) $display("FAIL reset_cursor got %0d want 0", cursor); else n_pass++;
        n_chk++; if (guess_word !== 20'd0) $display("FAIL reset_guess got %h want 0", guess_word); else n_pass++;
        n_chk++; if ({exact_mask, present_mask} !== 8'd0) $display("FAIL reset_masks got %b want 0", {exact_mask, present_mask}); else n_pass++;
        n_chk++; if ({guess_count, score_done, win, lose} !== 6'd0) $display("FAIL reset_misc got %b want 0", {guess_count, score_done, win, lose}); else n_pass++;
    endtask

    task automatic test_default_secret();
        logic [3:0] ex, pr;
        int cyc;
        press(5'd0, 1'b1, 1'b0);
        enter_word(word4(1, 8, 19, 18));
        wait_score(cyc);
        model_score(DEF_SECRET, word4(1, 8, 19, 18), ex, pr);
        n_chk++; if (cyc !== 5) $display("FAIL def_latency got %0d want 5", cyc); else n_pass++;
        n_chk++; if ({exact_mask, present_mask} !== {ex, pr}) $display("FAIL def_masks got %b want %b", {exact_mask, present_mask}, {ex, pr}); else n_pass++;
        n_chk++; if ({state_o, guess_count} !== {3'd3, 3'd1}) $display("FAIL def_state got %0d/%0d want 3/1", state_o, guess_count); else n_pass++;
    endtask

    task automatic test_win();
        int cyc;
        do_reset();
        load_secret(word4(1, 8, 19, 18));
        press(5'd0, 1'b1, 1'b0);
        enter_word(word4(1, 8, 19, 18));
        wait_score(cyc);
        n_chk++; if (cyc !== 5) $display("FAIL win_latency got %0d want 5", cyc); else n_pass++;
        n_chk++; if ({exact_mask, present_mask} !== 8'hF0) $display("FAIL win_masks got %b want 11110000", {exact_mask, present_mask}); else n_pass++;
        n_chk++; if ({state_o, win, lose, guess_count} !== {3'd4, 1'b1, 1'b0, 3'd1}) $display("FAIL win_verdict got %0d %b%b %0d want 4 10 1", state_o, win, lose, guess_count); else n_pass++;
        n_chk++; if (score_done !== 1'b0) $display("FAIL win_done_once got %b want 0", score_done); else n_pass++;
        press(5'd0, 1'b1, 1'b0);
        n_chk++; if ({state_o, guess_count, win} !== {3'd0, 3'd0, 1'b0}) $display("FAIL win_to_idle got %0d %0d %b want 0 0 0", state_o, guess_count, win); else n_pass++;
        n_chk++; if ({guess_word, exact_mask} !== 24'd0) $display("FAIL win_clear got %h want 0", {guess_word, exact_mask}); else n_pass++;
    endtask

    task automatic test_sibt();
        int cyc;
        press(5'd0, 1'b1, 1'b0);
        enter_word(word4(18, 8, 1, 19));
        wait_score(cyc);
        n_chk++; if (exact_mask !== 4'b0010) $display("FAIL sibt_exact got %b want 0010", exact_mask); else n_pass++;
        n_chk++; if (present_mask !== 4'b1101) $display("FAIL sibt_present got %b want 1101", present_mask); else n_pass++;
    endtask

    task automatic test_abba();
        int cyc;
        do_reset();
        load_secret(word4(0, 1, 1, 0));
        press(5'd0, 1'b1, 1'b0);
        secret_load = 1'b1;
        secret_in = word4(1, 1, 1, 1);
        enter_word(word4(1, 1, 1, 1));
        wait_score(cyc);
        secret_load = 1'b0;
        n_chk++; if (exact_mask !== 4'b0110) $display("FAIL abba_exact got %b want 0110", exact_mask); else n_pass++;
        n_chk++; if (present_mask !== 4'b0000) $display("FAIL abba_present got %b want 0000", present_mask); else n_pass++;
        n_chk++; if (state_o !== 3'd3) $display("FAIL abba_state got %0d want 3", state_o); else n_pass++;
    endtask

    task automatic test_edit();
        do_reset();
        press(5'd0, 1'b1, 1'b0);
        press(5'd0, 1'b1, 1'b0);
        n_chk++; if (cursor !== 3'd1) $display("FAIL edit_a got %0d want 1", cursor); else n_pass++;
        press(5'd0, 1'b0, 1'b1);
        n_chk++; if ({cursor, guess_word} !== 23'd0) $display("FAIL edit_back got %0d %h want 0 0", cursor, guess_word); else n_pass++;
        press(5'd0, 1'b0, 1'b1);
        n_chk++; if (cursor !== 3'd0) $display("FAIL edit_back0 got %0d want 0", cursor); else n_pass++;
        press(5'd27, 1'b1, 1'b0);
        n_chk++; if (cursor !== 3'd0) $display("FAIL edit_invalid got %0d want 0", cursor); else n_pass++;
        press(5'd25, 1'b1, 1'b0);
        n_chk++; if ({cursor, guess_word[4:0]} !== {3'd1, 5'd25}) $display("FAIL edit_z got %0d %0d want 1 25", cursor, guess_word[4:0]); else n_pass++;
        press(5'd2, 1'b1, 1'b1);
        n_chk++; if ({cursor, guess_word[9:5]} !== {3'd2, 5'd2}) $display("FAIL edit_both got %0d %0d want 2 2", cursor, guess_word[9:5]); else n_pass++;
        @(negedge clk);
        letter_in = 5'd3;
        enter = 1'b0;
        repeat (4) @(negedge clk);
        enter = 1'b1;
        n_chk++; if ({cursor, guess_word[14:10]} !== {3'd3, 5'd3}) $display("FAIL edit_held got %0d %0d want 3 3", cursor, guess_word[14:10]); else n_pass++;
    endtask

    task automatic test_random_games();
        logic [19:0] sec, g;
        logic [3:0]  ex, pr;
        int cyc, exp_cnt, exp_st;
        do_reset();
        for (int game = 0; game < 4; game++) begin
            sec = rand_word();
            load_secret(sec);
            exp_cnt = 0;
            for (int n = 1; n <= 6; n++) begin
                press(5'd0, 1'b1, 1'b0);
                n_chk++; if ({state_o, cursor, exact_mask} !== {3'd1, 3'd0, 4'd0}) $display("FAIL rnd_entry got %0d %0d %b want 1 0 0", state_o, cursor, exact_mask); else n_pass++;
                g = rand_word();
                if (game != 0 && $urandom_range(3, 0) == 0) g = sec;
                while (game == 0 && g == sec) g = rand_word();
                enter_word(g);
                wait_score(cyc);
                model_score(sec, g, ex, pr);
                exp_cnt++;
                exp_st = (ex == 4'hF) ? 4 : (exp_cnt == 6) ? 5 : 3;
                n_chk++; if (cyc !== 5) $display("FAIL rnd_latency got %0d want 5", cyc); else n_pass++;
                n_chk++; if ({exact_mask, present_mask} !== {ex, pr}) $display("FAIL rnd_masks sec %h guess %h got %b want %b", sec, g, {exact_mask, present_mask}, {ex, pr}); else n_pass++;
                n_chk++; if ({int'(state_o), int'(guess_count)} !== {exp_st, exp_cnt}) $display("FAIL rnd_state got %0d/%0d want %0d/%0d", state_o, guess_count, exp_st, exp_cnt); else n_pass++;
                n_chk++; if ({win, lose} !== {exp_st == 4, exp_st == 5}) $display("FAIL rnd_verdict got %b%b want %b%b", win, lose, exp_st == 4, exp_st == 5); else n_pass++;
                if (exp_st != 3) begin
                    press(5'd0, 1'b1, 1'b0);
                    n_chk++; if ({state_o, guess_count, win, lose} !== 8'd0) $display("FAIL rnd_idle got %0d %0d %b%b want 0 0 00", state_o, guess_count, win, lose); else n_pass++;
                    break;
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] ex, pr;
        int cyc;
        do_reset();
        load_secret(rand_word());
        press(5'd0, 1'b1, 1'b0);
        enter_word(rand_word());
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++; if ({state_o, cursor, guess_count} !== 9'd0) $display("FAIL mid_state got %0d %0d %0d want 0 0 0", state_o, cursor, guess_count); else n_pass++;
        n_chk++; if ({guess_word, exact_mask, present_mask, score_done, win, lose} !== 31'd0) $display("FAIL mid_outs got %h want 0", {guess_word, exact_mask, present_mask, score_done, win, lose}); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        press(5'd0, 1'b1, 1'b0);
        enter_word(word4(1, 8, 19, 18));
        wait_score(cyc);
        model_score(DEF_SECRET, word4(1, 8, 19, 18), ex, pr);
        n_chk++; if ({exact_mask, present_mask} !== {ex, pr}) $display("FAIL mid_secret got %b want %b", {exact_mask, present_mask}, {ex, pr}); else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        enter = 1'b1;
        back = 1'b1;
        secret_load = 1'b0;
        secret_in = '0;
        letter_in = '0;
        test_reset();
        test_default_secret();
        test_win();
        test_sibt();
        test_abba();
        test_edit();
        test_random_games();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
